ibex_rf_write_buffer: RTL and testbench

Write-back buffer between the Ibex writeback stage and the cached register file write port. It absorbs register writes while the register file signals `reg_stall_o` and queues them in order. It drains one write per unstalled cycle and forwards pending write data to the two read ports, so the ID stage never observes stale operands.

---
 rtl/ibex_rf_write_buffer.sv | 153 +++++++++++++++
 tb/tb_ibex_rf_write_buffer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_rf_write_buffer.sv
// ibex_rf_write_buffer: in-order write-back queue between the Ibex writeback stage and a
// register file that can stall its write port. Writes are queued while rf_stall_i is high
// and drained one per unstalled cycle. Pending write data is either forwarded to the ID read
// ports or flagged as a hazard.
//
// Build option: define IBEX_RF_WB_FORWARD_EN to build the forwarding muxes. hazard_o is then
// tied to 0. Without it, reads pass straight through and hazard_o flags reads that hit a
// pending write.
//
// Ports:
//   clk_i, rst_ni                       clock, asynchronous active-low reset
//   wb_we_i/wb_waddr_i/wb_wdata_i       write request from writeback
//   wb_ready_o                          write can be accepted this cycle
//   rf_we_o/rf_waddr_o/rf_wdata_o       write port towards the register file
//   rf_stall_i                          register file write-port stall
//   raddr_a_i/raddr_b_i                 ID read addresses
//   rf_rdata_a_i/rf_rdata_b_i           register file read data
//   rdata_a_o/rdata_b_o                 operand data delivered to ID
//   hazard_o                            read hits a pending write that is not forwarded
//   pending_cnt_o, empty_o              occupancy
module ibex_rf_write_buffer #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 4,
  parameter bit          RV32E     = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wb_we_i,
  input  logic [4:0]                 wb_waddr_i,
  input  logic [DataWidth-1:0]       wb_wdata_i,
  output logic                       wb_ready_o,
  output logic                       rf_we_o,
  output logic [4:0]                 rf_waddr_o,
  output logic [DataWidth-1:0]       rf_wdata_o,
  input  logic                       rf_stall_i,
  input  logic [4:0]                 raddr_a_i,
  input  logic [4:0]                 raddr_b_i,
  input  logic [DataWidth-1:0]       rf_rdata_a_i,
  input  logic [DataWidth-1:0]       rf_rdata_b_i,
  output logic [DataWidth-1:0]       rdata_a_o,
  output logic [DataWidth-1:0]       rdata_b_o,
  output logic                       hazard_o,
  output logic [$clog2(Depth):0]     pending_cnt_o,
  output logic                       empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [4:0]           mem_addr_q [Depth];
  logic [DataWidth-1:0] mem_data_q [Depth];
  logic [PtrW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]      count_q, count_d;

  logic empty, pop, push;
  logic hit_a, hit_b;
  logic [PtrW-1:0] rd_idx;

  assign empty      = (count_q == '0);
  assign pop        = !empty && !rf_stall_i;
  assign wb_ready_o = (count_q < DepthCnt) || pop;
  // x0 writes are acknowledged but never stored.
  assign push       = wb_we_i && wb_ready_o && (wb_waddr_i != 5'd0);

  assign rf_we_o       = pop;
  assign rf_waddr_o    = empty ? 5'd0 : mem_addr_q[head_q];
  assign rf_wdata_o    = empty ? '0   : mem_data_q[head_q];
  assign pending_cnt_o = count_q;
  assign empty_o       = empty;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop)  head_d = head_q + 1'b1;
    if (push) tail_d = tail_q + 1'b1;
    // A push into an empty queue cannot pop in the same cycle since pop needs !empty.
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset: only entries inside the occupancy window are ever used.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_addr_q[tail_q] <= wb_waddr_i;
      mem_data_q[tail_q] <= wb_wdata_i;
    end
  end

`ifdef IBEX_RF_WB_FORWARD_EN
  logic [DataWidth-1:0] fwd_a, fwd_b;
`endif

  // Walk from head to tail so a later (younger) match overrides an older one. The head entry
  // popping this cycle is still in the window.
  always_comb begin
    hit_a  = 1'b0;
    hit_b  = 1'b0;
    rd_idx = '0;
`ifdef IBEX_RF_WB_FORWARD_EN
    fwd_a  = '0;
    fwd_b  = '0;
`endif
    for (int unsigned i = 0; i < Depth; i++) begin
      rd_idx = head_q + PtrW'(i);
      if (CntW'(i) < count_q) begin
        if ((raddr_a_i != 5'd0) && (mem_addr_q[rd_idx] == raddr_a_i)) begin
          hit_a = 1'b1;
`ifdef IBEX_RF_WB_FORWARD_EN
          fwd_a = mem_data_q[rd_idx];
`endif
        end
        if ((raddr_b_i != 5'd0) && (mem_addr_q[rd_idx] == raddr_b_i)) begin
          hit_b = 1'b1;
`ifdef IBEX_RF_WB_FORWARD_EN
          fwd_b = mem_data_q[rd_idx];
`endif
        end
      end
    end
  end

`ifdef IBEX_RF_WB_FORWARD_EN
  assign rdata_a_o = (raddr_a_i == 5'd0) ? '0 : (hit_a ? fwd_a : rf_rdata_a_i);
  assign rdata_b_o = (raddr_b_i == 5'd0) ? '0 : (hit_b ? fwd_b : rf_rdata_b_i);
  assign hazard_o  = 1'b0;
`else
  assign rdata_a_o = (raddr_a_i == 5'd0) ? '0 : rf_rdata_a_i;
  assign rdata_b_o = (raddr_b_i == 5'd0) ? '0 : rf_rdata_b_i;
  assign hazard_o  = hit_a || hit_b;
`endif

  // RV32E has only x0..x15.
  rv32e_addr_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (RV32E && wb_we_i) |-> !wb_waddr_i[4]);

endmodule

// File: tb/tb_ibex_rf_write_buffer.sv
module tb_ibex_rf_write_buffer;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          wb_we_i;
  logic [4:0]    wb_waddr_i;
  logic [DW-1:0] wb_wdata_i;
  logic          wb_ready_o;
  logic          rf_we_o;
  logic [4:0]    rf_waddr_o;
  logic [DW-1:0] rf_wdata_o;
  logic          rf_stall_i;
  logic [4:0]    raddr_a_i, raddr_b_i;
  logic [DW-1:0] rf_rdata_a_i, rf_rdata_b_i;
  logic [DW-1:0] rdata_a_o, rdata_b_o;
  logic          hazard_o;
  logic [2:0]    pending_cnt_o;
  logic          empty_o;

  int checks = 0;
  int errors = 0;

  ibex_rf_write_buffer #(.DataWidth(DW), .Depth(DEPTH), .RV32E(1'b0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i),
    .wb_ready_o(wb_ready_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .rf_stall_i(rf_stall_i),
    .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i),
    .rf_rdata_a_i(rf_rdata_a_i), .rf_rdata_b_i(rf_rdata_b_i),
    .rdata_a_o(rdata_a_o), .rdata_b_o(rdata_b_o),
    .hazard_o(hazard_o), .pending_cnt_o(pending_cnt_o), .empty_o(empty_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: the pending writes as an ordered list, oldest first.
  typedef struct packed {
    logic [4:0]    addr;
    logic [DW-1:0] data;
  } entry_t;
  entry_t q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Youngest pending write to addr, if any.
  task automatic lookup(input logic [4:0] addr, output logic hit, output logic [DW-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (addr != 0)
      foreach (q[i]) if (q[i].addr == addr) begin hit = 1'b1; d = q[i].data; end
  endtask

  task automatic check_all();
    logic          will_pop, ha, hb;
    logic [DW-1:0] da, db, ea, eb;
    will_pop = (q.size() > 0) && !rf_stall_i;
    lookup(raddr_a_i, ha, da);
    lookup(raddr_b_i, hb, db);
`ifdef IBEX_RF_WB_FORWARD_EN
    ea = (raddr_a_i == 0) ? '0 : (ha ? da : rf_rdata_a_i);
    eb = (raddr_b_i == 0) ? '0 : (hb ? db : rf_rdata_b_i);
    check("hazard", hazard_o, 0);
`else
    ea = (raddr_a_i == 0) ? '0 : rf_rdata_a_i;
    eb = (raddr_b_i == 0) ? '0 : rf_rdata_b_i;
    check("hazard", hazard_o, ha || hb);
`endif
    check("ready", wb_ready_o, (q.size() < DEPTH) || will_pop);
    check("rf_we", rf_we_o, will_pop);
    check("rf_waddr", rf_waddr_o, q.size() > 0 ? q[0].addr : 5'd0);
    check("rf_wdata", rf_wdata_o, q.size() > 0 ? q[0].data : '0);
    check("count", pending_cnt_o, q.size());
    check("empty", empty_o, q.size() == 0);
    check("rdata_a", rdata_a_o, ea);
    check("rdata_b", rdata_b_o, eb);
  endtask

  // Apply inputs at the negedge, then compare once they settle.
  task automatic set_in(input logic we, input logic [4:0] wa, input logic [DW-1:0] wd,
                        input logic stall);
    wb_we_i = we; wb_waddr_i = wa; wb_wdata_i = wd; rf_stall_i = stall;
    #1;
    check_all();
  endtask

  // Clock the DUT and the model together.
  task automatic adv();
    logic will_pop, ready;
    @(posedge clk_i);
    will_pop = (q.size() > 0) && !rf_stall_i;
    ready    = (q.size() < DEPTH) || will_pop;
    if (will_pop) void'(q.pop_front());
    if (wb_we_i && ready && wb_waddr_i != 0) q.push_back('{addr: wb_waddr_i, data: wb_wdata_i});
    @(negedge clk_i);
  endtask

  task automatic step(input logic we, input logic [4:0] wa, input logic [DW-1:0] wd,
                      input logic stall);
    set_in(we, wa, wd, stall);
    adv();
  endtask

  initial begin
    rst_ni = 1'b0;
    wb_we_i = 0; wb_waddr_i = 0; wb_wdata_i = 0; rf_stall_i = 0;
    raddr_a_i = 5'd9; raddr_b_i = 5'd0;
    rf_rdata_a_i = 32'h1234_5678; rf_rdata_b_i = 32'h9abc_def0;
    @(negedge clk_i);
    @(negedge clk_i);
    set_in(0, 0, 0, 0);
    check("reset_rdata_a", rdata_a_o, 32'h1234_5678);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Single write lands on the register file port one cycle later.
    step(1, 5, 32'hDEAD_BEEF, 0);
    set_in(0, 0, 0, 0);
    check("single_we", rf_we_o, 1);
    check("single_waddr", rf_waddr_o, 5);
    check("single_wdata", rf_wdata_o, 32'hDEAD_BEEF);
    adv();
    set_in(0, 0, 0, 0);
    check("single_empty", empty_o, 1);
    adv();

    // Fill under stall, then drain in order.
    for (int i = 1; i <= 4; i++) step(1, 5'(i), 32'(i * 8'h11), 1);
    set_in(1, 5'd9, 32'h99, 1);
    check("full_count", pending_cnt_o, 4);
    check("full_ready", wb_ready_o, 0);
    adv();
    for (int i = 1; i <= 4; i++) begin
      set_in(0, 0, 0, 0);
      check("drain_we", rf_we_o, 1);
      check("drain_order", rf_waddr_o, i);
      adv();
    end

    // Push into a full queue while it pops; x7 comes out fifth after the pointers wrap.
    for (int i = 1; i <= 4; i++) step(1, 5'(i + 10), 32'(i), 1);
    set_in(1, 5'd7, 32'h77, 0);
    check("pp_ready", wb_ready_o, 1);
    adv();
    set_in(0, 0, 0, 1);
    check("pp_count", pending_cnt_o, 4);
    adv();
    for (int i = 2; i <= 5; i++) begin
      set_in(0, 0, 0, 0);
      check("pp_order", rf_waddr_o, i == 5 ? 5'd7 : 5'(i + 10));
      adv();
    end

    // Two pending writes to x3: the younger one is what a read must see.
    raddr_a_i = 3; raddr_b_i = 3; rf_rdata_a_i = 0; rf_rdata_b_i = 0;
    step(1, 3, 32'hA, 1);
    step(1, 3, 32'hB, 1);
    set_in(0, 0, 0, 1);
`ifdef IBEX_RF_WB_FORWARD_EN
    check("fwd_a", rdata_a_o, 32'hB);
    check("fwd_b", rdata_b_o, 32'hB);
`else
    check("nofwd_hazard", hazard_o, 1);
    check("nofwd_a", rdata_a_o, 0);
`endif
    raddr_a_i = 0;
    #1;
    check("x0_read", rdata_a_o, 0);
    raddr_a_i = 3;
    adv();
    step(0, 0, 0, 0);
    set_in(0, 0, 0, 0);
`ifndef IBEX_RF_WB_FORWARD_EN
    check("hazard_last_pop", hazard_o, 1);
`endif
    adv();
    set_in(0, 0, 0, 0);
    check("hazard_fell", hazard_o, 0);
    adv();

    // x0 writes are acknowledged but not stored.
    set_in(1, 0, 32'h55, 0);
    check("x0_ready", wb_ready_o, 1);
    adv();
    set_in(0, 0, 0, 0);
    check("x0_count", pending_cnt_o, 0);
    adv();

    // Asynchronous reset with three queued entries discards them.
    for (int i = 0; i < 3; i++) step(1, 5'(i + 20), 32'(i + 100), 1);
    #2;
    rst_ni = 1'b0;
    q.delete();
    #1;
    check("rst_count", pending_cnt_o, 0);
    check("rst_empty", empty_o, 1);
    check("rst_waddr", rf_waddr_o, 0);
    check("rst_ready", wb_ready_o, 1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0);
      check("rst_no_we", rf_we_o, 0);
      adv();
    end

    // Random traffic against the model; small address range makes read hits common.
    for (int n = 0; n < 400; n++) begin
      raddr_a_i    = 5'($urandom_range(0, 7));
      raddr_b_i    = 5'($urandom_range(0, 7));
      rf_rdata_a_i = $urandom;
      rf_rdata_b_i = $urandom;
      step(1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 2) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
